mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Clocked main-memory responder: the memory-side end of the cache<->memory interface.
//  Serves single-word read/write requests issued by the cache controller.
//  Models a fixed access latency and signals completion with a one-cycle Done pulse.
//  Sits between Cache (initiator) and nothing else; it is the backing store.
// PARAMETERS
//  ADDR_W   10   byte-address width of address_mem
//  DATA_W   32   word width
//  DEPTH    256  words stored (2^(ADDR_W-2))
//  LATENCY  4    cycles from request acceptance to Done; legal range 1..15
// PORTS
//  clk              input   1       rising-edge clock
//  rst              input   1       synchronous, active-high reset
//  req_valid        input   1       cache presents a request this cycle
//  read_write_mem   input   1       1 = write, 0 = read
//  address_mem      input   ADDR_W  byte address; bits [1:0] ignored (word aligned)
//  write_data_mem   input   DATA_W  write data
//  read_data_mem    output  DATA_W  read data, valid when Done=1, held afterwards
//  Done             output  1       one-cycle completion pulse
//  busy             output  1       1 while a request is outstanding
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): state=IDLE, counter=0, Done=0, busy=0,
//    read_data_mem=0, every memory word cleared to 0. Reset mid-transaction aborts it:
//    no Done, no write performed.
//  - FSM states: IDLE, WAIT, RESP.
//    IDLE: if req_valid, latch rw, word index = address_mem[ADDR_W-1:2], and wdata;
//      load counter=LATENCY-1; busy<=1; go WAIT (or RESP directly if LATENCY=1).
//    WAIT: counter decrements each cycle; when counter==1 go RESP.
//    RESP: one cycle. Write: mem[idx]<=wdata. Read: read_data_mem<=mem[idx].
//      Done<=1 for exactly this cycle; busy<=0 on exit; return to IDLE.
//  - Latency: req_valid sampled at edge N -> Done high during cycle N+LATENCY.
//  - Inputs changing while busy=1 are ignored; req_valid asserted in WAIT/RESP is
//    dropped (no queueing). Cache must wait for Done, then re-present.
//  - Back-to-back: req_valid high in the cycle after Done is accepted; minimum request
//    spacing is LATENCY+1 cycles.
//  - Read after write to the same word returns the new data (write commits in RESP).
//  - read_data_mem is unchanged by writes and holds the last read value until the next
//    read's RESP.
//  - Address wrap: only bits [ADDR_W-1:2] index; no out-of-range case exists.
//  - Counter width: 4 bits, never underflows (loaded only from IDLE).
// STRUCTURE
//  - Shared package mem_pkg: ADDR_W, DATA_W, DEPTH constants; state enum
//    {IDLE=2'd0, WAIT=2'd1, RESP=2'd2}; RW_READ=1'b0 / RW_WRITE=1'b1.
//  - One sub-module: mem_word_array (DEPTH x DATA_W, sync write, sync read, sync clear),
//    instantiated once; FSM, latency counter and request latches in mem_responder.
// TESTING
//  1. Reset, then read addr 0x010 -> Done at req+4 cycles, read_data_mem=0x00000000.
//  2. Write 0xDEADBEEF to 0x020, then read 0x020 -> Done each after 4 cycles,
//     read returns 0xDEADBEEF; read of 0x023 (same word) also returns 0xDEADBEEF.
//  3. During WAIT of read 0x020, drive req_valid with write 0x020/0x12345678 ->
//     ignored: only one Done, subsequent read still 0xDEADBEEF.
//  4. Assert rst two cycles into a write of 0x55AA55AA to 0x040 -> no Done,
//     busy=0 next cycle, later read of 0x040 returns 0x00000000.
//  5. Back-to-back: write 0x3FC/0xCAFEF00D, req_valid in cycle after Done with read
//     0x3FC -> accepted immediately, Done 4 cycles later with 0xCAFEF00D.
//  6. LATENCY=1 build: read 0x004 -> Done exactly one cycle after acceptance, busy high
//     for that one cycle only.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the main-memory responder.
//   ADDR_W : byte-address width of the request address
//   DATA_W : stored word width
//   DEPTH  : number of stored words (one per 4-byte aligned address)
//   IDX_W  : word-index width derived from DEPTH
//   CNT_W  : latency counter width (covers LATENCY 1..15)
//   state_t: responder FSM states
//   RW_*   : encoding of the read_write_mem request bit
package mem_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/mem_word_array.sv
// Word storage for the responder: DEPTH x DATA_W array with a synchronous
// write port, a synchronous (registered) read port and a synchronous clear.
//   clk   : rising-edge clock
//   clr   : synchronous clear of every word and of the read register
//   we    : write wdata into word idx at the clock edge
//   re    : load word idx into the read register at the clock edge
//   idx   : word index shared by read and write
//   wdata : write data
//   rdata : registered read data; holds its value while re is low
module mem_word_array #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_reg;

  // The clear forces a register-based array: every word must read as zero
  // after reset, which a block RAM cannot do in a single cycle.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rdata_reg <= '0;
    end else begin
      if (we) begin
        mem[idx] <= wdata;
      end
      if (re) begin
        rdata_reg <= mem[idx];
      end
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/mem_responder.sv
// Main-memory responder: the backing store behind the cache. Accepts one
// single-word read or write at a time, waits a fixed latency, then performs
// the access and pulses Done for one cycle.
//   clk            : rising-edge clock
//   rst            : synchronous active-high reset (aborts any transaction,
//                    clears the whole memory)
//   req_valid      : request present this cycle (only accepted when idle)
//   read_write_mem : 1 = write, 0 = read
//   address_mem    : byte address; bits [1:0] are ignored
//   write_data_mem : write data
//   read_data_mem  : read data, valid with Done and held until the next read
//   Done           : one-cycle completion pulse
//   busy           : high while a request is outstanding
// A request sampled at edge N produces Done high in the cycle after edge
// N+LATENCY. LATENCY must lie in 1..15.
module mem_responder
  import mem_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              read_write_mem,
  input  logic [ADDR_W-1:0] address_mem,
  input  logic [DATA_W-1:0] write_data_mem,
  output logic [DATA_W-1:0] read_data_mem,
  output logic              Done,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              rw_reg, rw_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              done_reg, done_next;
  logic              busy_reg, busy_next;
  logic              mem_we;
  logic              mem_re;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      rw_reg    <= RW_READ;
      idx_reg   <= '0;
      wdata_reg <= '0;
      done_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rw_reg    <= rw_next;
      idx_reg   <= idx_next;
      wdata_reg <= wdata_next;
      done_reg  <= done_next;
      busy_reg  <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rw_next    = rw_reg;
    idx_next   = idx_reg;
    wdata_next = wdata_reg;
    done_next  = 1'b0;
    busy_next  = busy_reg;
    mem_we     = 1'b0;
    mem_re     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          rw_next    = read_write_mem;
          // Shift then truncate: drops the byte offset and wraps the index.
          idx_next   = IDX_W'(address_mem >> 2);
          wdata_next = write_data_mem;
          cnt_next   = CNT_LOAD;
          busy_next  = 1'b1;
          state_next = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        // Counter is only loaded from IDLE and left at 1, so it cannot wrap.
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == CNT_W'(1)) begin
          state_next = RESP;
        end
      end
      RESP: begin
        // The access commits on the edge leaving RESP, the same edge that
        // raises Done, so a following read always sees this write.
        mem_we     = (rw_reg == RW_WRITE);
        mem_re     = (rw_reg == RW_READ);
        done_next  = 1'b1;
        busy_next  = 1'b0;
        cnt_next   = '0;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  mem_word_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .clr   (rst),
    .we    (mem_we),
    .re    (mem_re),
    .idx   (idx_reg),
    .wdata (wdata_reg),
    .rdata (read_data_mem)
  );

  assign Done = done_reg;
  assign busy = busy_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a LATENCY=4 instance for the main
// scenarios and a LATENCY=1 instance for the minimum-latency build.
module tb_mem_responder;
  import mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // LATENCY = 4 instance
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              rw = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic [DATA_W-1:0] rdata;
  logic              done;
  logic              busy;

  // LATENCY = 1 instance
  logic              rst1 = 1'b1;
  logic              req_valid1 = 1'b0;
  logic              rw1 = 1'b0;
  logic [ADDR_W-1:0] addr1 = '0;
  logic [DATA_W-1:0] wdata1 = '0;
  logic [DATA_W-1:0] rdata1;
  logic              done1;
  logic              busy1;

  mem_responder #(.LATENCY(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .read_write_mem (rw),
    .address_mem    (addr),
    .write_data_mem (wdata),
    .read_data_mem  (rdata),
    .Done           (done),
    .busy           (busy)
  );

  mem_responder #(.LATENCY(1)) dut1 (
    .clk            (clk),
    .rst            (rst1),
    .req_valid      (req_valid1),
    .read_write_mem (rw1),
    .address_mem    (addr1),
    .write_data_mem (wdata1),
    .read_data_mem  (rdata1),
    .Done           (done1),
    .busy           (busy1)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Called at #1 after an edge; returns at #1 after the accepting edge.
  task automatic issue(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    rw = w;
    addr = a;
    wdata = d;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Full transaction on the LATENCY=4 instance; returns at #1 in the Done
  // cycle so a following call is issued back-to-back.
  task automatic txn(input string tag, input logic w, input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] exp_rd);
    int n;
    issue(w, a, d);
    chk({tag, "_busy_start"}, 32'(busy), 32'd1);
    chk({tag, "_done_low_start"}, 32'(done), 32'd0);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd4);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, "_rdata"}, rdata, exp_rd);
    $display("txn %s rw=%0d addr=0x%03h wdata=0x%08h lat=%0d rdata=0x%08h",
             tag, w, a, d, n, rdata);
  endtask

  initial begin
    int cnt;
    int first_k;
    logic [DATA_W-1:0] first_rd;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    rst1 = 1'b0;
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rdata", rdata, 32'h0);

    // 1: read of cleared memory
    txn("t1_rd010", RW_READ, 10'h010, 32'h0, 32'h0000_0000);

    // 2: write then read, including a non-aligned address of the same word
    txn("t2_wr020", RW_WRITE, 10'h020, 32'hDEAD_BEEF, 32'h0000_0000);
    txn("t2_rd020", RW_READ, 10'h020, 32'h0, 32'hDEAD_BEEF);
    txn("t2_rd023", RW_READ, 10'h023, 32'h0, 32'hDEAD_BEEF);

    // 3: request presented during WAIT must be dropped
    @(posedge clk);
    #1;
    issue(RW_READ, 10'h020, 32'h0);
    rw = RW_WRITE;
    addr = 10'h020;
    wdata = 32'h1234_5678;
    req_valid = 1'b1;
    cnt = 0;
    first_k = 0;
    first_rd = '0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) req_valid = 1'b0;
      if (done === 1'b1) begin
        cnt++;
        if (cnt == 1) begin
          first_k = k;
          first_rd = rdata;
        end
      end
    end
    chk("t3_done_count", 32'(cnt), 32'd1);
    chk("t3_latency", 32'(first_k), 32'd4);
    chk("t3_rdata", first_rd, 32'hDEAD_BEEF);
    $display("txn t3_rd020_with_dropped_wr done_count=%0d lat=%0d rdata=0x%08h", cnt, first_k, first_rd);
    txn("t3_rd020_after", RW_READ, 10'h020, 32'h0, 32'hDEAD_BEEF);

    // 4: reset two cycles into a write aborts it
    @(posedge clk);
    #1;
    issue(RW_WRITE, 10'h040, 32'h55AA_55AA);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t4_busy_after_rst", 32'(busy), 32'd0);
    chk("t4_done_after_rst", 32'(done), 32'd0);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) cnt++;
    end
    chk("t4_no_done", 32'(cnt), 32'd0);
    $display("txn t4_wr040_aborted done_count=%0d", cnt);
    txn("t4_rd040", RW_READ, 10'h040, 32'h0, 32'h0000_0000);
    txn("t4_rd020_cleared", RW_READ, 10'h020, 32'h0, 32'h0000_0000);

    // 5: back-to-back write then read at the top word
    txn("t5_wr3fc", RW_WRITE, 10'h3FC, 32'hCAFE_F00D, 32'h0000_0000);
    txn("t5_rd3fc", RW_READ, 10'h3FC, 32'h0, 32'hCAFE_F00D);
    @(posedge clk);
    #1;
    chk("t5_done_pulse_ends", 32'(done), 32'd0);

    // 6: LATENCY=1 build
    rw1 = RW_WRITE;
    addr1 = 10'h004;
    wdata1 = 32'hA5A5_0001;
    req_valid1 = 1'b1;
    @(posedge clk);
    #1;
    req_valid1 = 1'b0;
    chk("t6_wr_busy", 32'(busy1), 32'd1);
    @(posedge clk);
    #1;
    chk("t6_wr_done", 32'(done1), 32'd1);
    chk("t6_wr_rdata_held", rdata1, 32'h0);
    $display("txn t6_wr004 lat1 done=%0d rdata=0x%08h", done1, rdata1);
    @(posedge clk);
    #1;
    rw1 = RW_READ;
    addr1 = 10'h004;
    req_valid1 = 1'b1;
    @(posedge clk);
    #1;
    req_valid1 = 1'b0;
    chk("t6_rd_busy", 32'(busy1), 32'd1);
    chk("t6_rd_done_low", 32'(done1), 32'd0);
    @(posedge clk);
    #1;
    chk("t6_rd_done", 32'(done1), 32'd1);
    chk("t6_rd_busy_end", 32'(busy1), 32'd0);
    chk("t6_rd_rdata", rdata1, 32'hA5A5_0001);
    $display("txn t6_rd004 lat1 done=%0d busy=%0d rdata=0x%08h", done1, busy1, rdata1);
    @(posedge clk);
    #1;
    chk("t6_done_pulse_ends", 32'(done1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
